// File: rtl/stage_two_if.sv
// stage_two_if: the execute-stage bus. It carries stage_one's operands,
// control and sideband fields into stage_two, and carries the registered
// result, sidebands, flags and the busy stall request back out.
//   slave  : the execute stage's view (consumes in_*, drives busy/out_*)
//   master : the upstream/downstream view (drives in_*, consumes busy/out_*)
interface stage_two_if #(
  parameter int unsigned WIDTH = 16
);
  logic               halt_sys;
  logic [WIDTH-1:0]   in_alu_a;
  logic [WIDTH-1:0]   in_alu_b;
  logic [3:0]         in_alu_ctrl;
  logic [1:0]         in_memc;
  logic               in_reg_wr;
  logic               in_R0_en;
  logic [WIDTH-1:0]   in_R1_data;
  logic [7:0]         in_instr;

  logic               busy;
  logic [2*WIDTH-1:0] out_alu_result;
  logic [1:0]         out_memc;
  logic               out_reg_wr;
  logic               out_R0_en;
  logic [WIDTH-1:0]   out_R1_data;
  logic [7:0]         out_instr;
  logic               out_overflow;
  logic               out_div0;

  modport slave (
    input  halt_sys, in_alu_a, in_alu_b, in_alu_ctrl, in_memc, in_reg_wr,
           in_R0_en, in_R1_data, in_instr,
    output busy, out_alu_result, out_memc, out_reg_wr, out_R0_en,
           out_R1_data, out_instr, out_overflow, out_div0
  );

  modport master (
    output halt_sys, in_alu_a, in_alu_b, in_alu_ctrl, in_memc, in_reg_wr,
           in_R0_en, in_R1_data, in_instr,
    input  busy, out_alu_result, out_memc, out_reg_wr, out_R0_en,
           out_R1_data, out_instr, out_overflow, out_div0
  );
endinterface

// File: rtl/stage_two.sv
// stage_two: execute stage of the 16-bit pipelined CPU.
// Single-cycle ADD/SUB/AND/OR/SLL/SRL/SRA, plus iterative signed MUL
// (radix-2 shift-add) and DIV (restoring), one bit per cycle on operand
// magnitudes with signs applied in DONE. Result and sidebands are registered
// for the memory/writeback stage; busy stalls stage_one while MUL/DIV runs.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : stage_two_if slave (halt_sys, in_* operands/sidebands,
//          busy, out_* registered result/sidebands/flags)
module stage_two #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ITERS = 16
) (
  input logic        clk,
  input logic        rst,
  stage_two_if.slave bus
);

  localparam int unsigned CW = $clog2(ITERS) + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_e;

  typedef enum logic [3:0] {
    CTRL_ADD = 4'd0, CTRL_SUB = 4'd1, CTRL_AND = 4'd2, CTRL_OR  = 4'd3,
    CTRL_SLL = 4'd4, CTRL_SRL = 4'd5, CTRL_SRA = 4'd6, CTRL_MUL = 4'd7,
    CTRL_DIV = 4'd8
  } control_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 is_div_q, is_div_d;

  logic [2*WIDTH-1:0]   res_q, res_d;
  logic [1:0]           memc_q, memc_d;
  logic                 reg_wr_q, reg_wr_d;
  logic                 r0_en_q, r0_en_d;
  logic [WIDTH-1:0]     r1_data_q, r1_data_d;
  logic [7:0]           instr_q, instr_d;
  logic                 ovf_q, ovf_d;
  logic                 div0_q, div0_d;

  logic                 busy_c;

  logic [WIDTH-1:0]     a, b, a_mag, b_mag;
  logic [WIDTH-1:0]     add_res, sub_res, sra_res;
  logic [2*WIDTH-1:0]   alu_res;
  logic                 alu_ovf;
  logic                 start_mul, start_div, div_zero;
  control_e             ctrl;

  logic [WIDTH:0]       mul_hi;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift, div_diff;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   div_next;

  logic [2*WIDTH-1:0]   mul_res;
  logic [WIDTH-1:0]     quo, rem, quo_s, rem_s;
  logic                 div_ovf;

  assign a    = bus.in_alu_a;
  assign b    = bus.in_alu_b;
  assign ctrl = control_e'(bus.in_alu_ctrl);

  assign a_mag = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
  assign b_mag = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;

  assign add_res = a + b;
  assign sub_res = a - b;
  assign sra_res = $unsigned($signed(a) >>> b[3:0]);

  assign div_zero  = (b == '0);
  assign start_mul = (ctrl == CTRL_MUL);
  assign start_div = (ctrl == CTRL_DIV) && !div_zero;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (ctrl)
      CTRL_ADD: begin
        alu_res = {{WIDTH{add_res[WIDTH-1]}}, add_res};
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_res[WIDTH-1] != a[WIDTH-1]);
      end
      CTRL_SUB: begin
        alu_res = {{WIDTH{sub_res[WIDTH-1]}}, sub_res};
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_res[WIDTH-1] != a[WIDTH-1]);
      end
      CTRL_AND: alu_res = {{WIDTH{1'b0}}, a & b};
      CTRL_OR:  alu_res = {{WIDTH{1'b0}}, a | b};
      CTRL_SLL: alu_res = {{WIDTH{1'b0}}, a << b[3:0]};
      CTRL_SRL: alu_res = {{WIDTH{1'b0}}, a >> b[3:0]};
      CTRL_SRA: alu_res = {{WIDTH{1'b0}}, sra_res};
      default:  alu_res = '0;
    endcase
  end

  // MUL: acc holds {partial product, remaining multiplier bits}; add the
  // multiplicand into the upper half on a 1 bit, then shift right with carry.
  assign mul_hi   = acc_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q})
                             : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
  assign mul_next = {mul_hi, acc_q[WIDTH-1:1]};

  // DIV: acc holds {remainder, dividend/quotient}; the quotient bit shifts in
  // from the right as the dividend shifts out the top. No borrow => fits.
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb_q};
  assign div_ge    = !div_diff[WIDTH];
  assign div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                      acc_q[WIDTH-2:0], div_ge};

  assign mul_res = neg_res_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
  assign quo     = acc_q[WIDTH-1:0];
  assign rem     = acc_q[2*WIDTH-1:WIDTH];
  assign quo_s   = neg_res_q ? (~quo + WIDTH'(1)) : quo;
  assign rem_s   = neg_rem_q ? (~rem + WIDTH'(1)) : rem;
  // A positive quotient with the top bit set only arises from MIN / -1.
  assign div_ovf = !neg_res_q && quo[WIDTH-1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    is_div_d  = is_div_q;
    busy_c    = 1'b0;
    res_d     = '0;
    memc_d    = '0;
    reg_wr_d  = 1'b0;
    r0_en_d   = 1'b0;
    r1_data_d = '0;
    instr_d   = '0;
    ovf_d     = 1'b0;
    div0_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_mul || start_div) begin
          busy_c    = 1'b1;
          state_d   = start_mul ? ST_MUL : ST_DIV;
          cnt_d     = '0;
          acc_d     = {{WIDTH{1'b0}}, a_mag};
          opb_d     = b_mag;
          neg_res_d = a[WIDTH-1] ^ b[WIDTH-1];
          neg_rem_d = a[WIDTH-1];
          is_div_d  = start_div;
        end else begin
          div0_d    = (ctrl == CTRL_DIV);
          res_d     = alu_res;
          ovf_d     = alu_ovf;
          memc_d    = bus.in_memc;
          reg_wr_d  = bus.in_reg_wr && !alu_ovf && !div0_d;
          r0_en_d   = bus.in_R0_en;
          r1_data_d = bus.in_R1_data;
          instr_d   = bus.in_instr;
        end
      end
      ST_MUL, ST_DIV: begin
        busy_c = 1'b1;
        acc_d  = (state_q == ST_DIV) ? div_next : mul_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(ITERS - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d   = ST_IDLE;
        res_d     = is_div_q ? {rem_s, quo_s} : mul_res;
        ovf_d     = is_div_q && div_ovf;
        memc_d    = bus.in_memc;
        reg_wr_d  = bus.in_reg_wr && !ovf_d;
        r0_en_d   = bus.in_R0_en;
        r1_data_d = bus.in_R1_data;
        instr_d   = bus.in_instr;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
      res_q     <= '0;
      memc_q    <= '0;
      reg_wr_q  <= 1'b0;
      r0_en_q   <= 1'b0;
      r1_data_q <= '0;
      instr_q   <= '0;
      ovf_q     <= 1'b0;
      div0_q    <= 1'b0;
    end else if (!bus.halt_sys) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      is_div_q  <= is_div_d;
      res_q     <= res_d;
      memc_q    <= memc_d;
      reg_wr_q  <= reg_wr_d;
      r0_en_q   <= r0_en_d;
      r1_data_q <= r1_data_d;
      instr_q   <= instr_d;
      ovf_q     <= ovf_d;
      div0_q    <= div0_d;
    end
  end

  // busy is combinational but must read 0 while reset is held, even if a
  // MUL/DIV is sitting on the inputs.
  assign bus.busy           = rst && busy_c;
  assign bus.out_alu_result = res_q;
  assign bus.out_memc       = memc_q;
  assign bus.out_reg_wr     = reg_wr_q;
  assign bus.out_R0_en      = r0_en_q;
  assign bus.out_R1_data    = r1_data_q;
  assign bus.out_instr      = instr_q;
  assign bus.out_overflow   = ovf_q;
  assign bus.out_div0       = div0_q;

endmodule

// File: tb/tb_stage_two.sv
// tb_stage_two: self-checking bench for stage_two. Expected results come
// from an arithmetic reference model, are queued when an op is driven and
// popped when the registered result is due.
module tb_stage_two;

  localparam int unsigned W = 16;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2,
                         OP_OR  = 4'd3, OP_SLL = 4'd4, OP_SRL = 4'd5,
                         OP_SRA = 4'd6, OP_MUL = 4'd7, OP_DIV = 4'd8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  stage_two_if #(.WIDTH(W)) bus ();

  stage_two #(.WIDTH(W), .ITERS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic [1:0]  memc;
    logic        reg_wr;
    logic        r0;
    logic [15:0] r1;
    logic [7:0]  instr;
    logic        ovf;
    logic        div0;
    int          busy_cycles;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic [1:0] memc,
                                 input logic reg_wr, input logic r0,
                                 input logic [15:0] r1, input logic [7:0] instr);
    exp_t e;
    int sa, sb, r, q, rm, sh;
    longint p;
    logic [15:0] lo;
    sa = int'($signed(a));
    sb = int'($signed(b));
    sh = int'(b[3:0]);
    e.res = '0; e.ovf = 1'b0; e.div0 = 1'b0; e.busy_cycles = 0;
    e.memc = memc; e.r0 = r0; e.r1 = r1; e.instr = instr;
    case (op)
      OP_ADD: begin
        r = sa + sb; lo = r[15:0];
        e.res = {{16{lo[15]}}, lo};
        e.ovf = (r > 32767) || (r < -32768);
      end
      OP_SUB: begin
        r = sa - sb; lo = r[15:0];
        e.res = {{16{lo[15]}}, lo};
        e.ovf = (r > 32767) || (r < -32768);
      end
      OP_AND: e.res = {16'h0, a & b};
      OP_OR:  e.res = {16'h0, a | b};
      OP_SLL: begin lo = a << sh; e.res = {16'h0, lo}; end
      OP_SRL: begin lo = a >> sh; e.res = {16'h0, lo}; end
      OP_SRA: begin lo = $signed(a) >>> sh; e.res = {16'h0, lo}; end
      OP_MUL: begin
        p = longint'(sa) * longint'(sb);
        e.res = p[31:0];
        e.busy_cycles = 17;
      end
      OP_DIV: begin
        if (sb == 0) begin
          e.div0 = 1'b1;
        end else begin
          q = sa / sb; rm = sa % sb;
          e.res = {rm[15:0], q[15:0]};
          e.ovf = (q > 32767);
          e.busy_cycles = 17;
        end
      end
      default: e.res = '0;
    endcase
    e.reg_wr = reg_wr && !e.ovf && !e.div0;
    return e;
  endfunction

  task automatic set_inputs(input logic [3:0] op, input logic [15:0] a,
                            input logic [15:0] b, input logic [1:0] memc,
                            input logic reg_wr, input logic r0,
                            input logic [15:0] r1, input logic [7:0] instr);
    bus.in_alu_ctrl = op;
    bus.in_alu_a    = a;
    bus.in_alu_b    = b;
    bus.in_memc     = memc;
    bus.in_reg_wr   = reg_wr;
    bus.in_R0_en    = r0;
    bus.in_R1_data  = r1;
    bus.in_instr    = instr;
  endtask

  // Called shortly after a rising edge. Holds the op until its result is
  // registered, then returns shortly after that edge.
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] memc, input logic reg_wr,
                        input logic r0, input logic [15:0] r1,
                        input logic [7:0] instr, input int halt_at,
                        input int halt_len);
    exp_t e;
    exp_t g;
    int   nb;
    set_inputs(op, a, b, memc, reg_wr, r0, r1, instr);
    e = model(op, a, b, memc, reg_wr, r0, r1, instr);
    if (halt_at > 0) e.busy_cycles += halt_len;
    sb_q.push_back(e);
    nb = 0;
    #1;
    while (bus.busy === 1'b1 && nb < 200) begin
      nb++;
      if (nb == halt_at) begin
        bus.halt_sys = 1'b1;
        repeat (halt_len) begin
          @(posedge clk); #1;
          nb++;
          check_eq({tag, "_halt_busy"}, 32'(bus.busy), 32'd1);
          check_eq({tag, "_halt_out"}, bus.out_alu_result, 32'h0);
        end
        bus.halt_sys = 1'b0;
      end
      @(posedge clk); #1;
      check_eq({tag, "_bubble_res"}, bus.out_alu_result, 32'h0);
      check_eq({tag, "_bubble_side"},
               32'({bus.out_reg_wr, bus.out_memc, bus.out_R0_en,
                    bus.out_overflow, bus.out_div0, bus.out_instr,
                    bus.out_R1_data}), 32'h0);
    end
    if (nb >= 200) check_eq({tag, "_busy_timeout"}, 32'd1, 32'd0);
    @(posedge clk); #1;
    if (sb_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      g = sb_q.pop_front();
      check_eq({tag, "_result"}, bus.out_alu_result, g.res);
      check_eq({tag, "_reg_wr"}, 32'(bus.out_reg_wr), 32'(g.reg_wr));
      check_eq({tag, "_ovf"}, 32'(bus.out_overflow), 32'(g.ovf));
      check_eq({tag, "_div0"}, 32'(bus.out_div0), 32'(g.div0));
      check_eq({tag, "_side"},
               32'({bus.out_memc, bus.out_R0_en, bus.out_instr, bus.out_R1_data}),
               32'({g.memc, g.r0, g.instr, g.r1}));
      check_eq({tag, "_busy_cycles"}, 32'(nb), 32'(g.busy_cycles));
      check_eq({tag, "_busy_after"}, 32'(bus.busy),
               32'((op == OP_MUL) || (op == OP_DIV && b != 16'h0)));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, 32'(bus.busy), 32'h0);
    check_eq({tag, "_result"}, bus.out_alu_result, 32'h0);
    check_eq({tag, "_side"},
             32'({bus.out_reg_wr, bus.out_memc, bus.out_R0_en,
                  bus.out_overflow, bus.out_div0, bus.out_instr}), 32'h0);
    check_eq({tag, "_r1"}, 32'(bus.out_R1_data), 32'h0);
  endtask

  initial begin
    rst          = 1'b0;
    bus.halt_sys = 1'b0;
    set_inputs(OP_AND, 16'h0, 16'h0, 2'b00, 1'b0, 1'b0, 16'h0, 8'h00);
    #1;
    check_all_zero("reset_init");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // Abort a MUL at counter 7 with an asynchronous reset mid-cycle.
    set_inputs(OP_MUL, 16'hFFFD, 16'd5, 2'b01, 1'b1, 1'b1, 16'h1234, 8'hA5);
    repeat (8) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_all_zero("reset_mid_mul");
    set_inputs(OP_ADD, 16'd3, 16'd4, 2'b00, 1'b1, 1'b0, 16'h0, 8'h00);
    @(posedge clk); #1;
    check_all_zero("reset_held");
    rst = 1'b1;

    run_op("add_3_4",   OP_ADD, 16'd3,    16'd4,    2'b10, 1'b1, 1'b0, 16'hBEEF, 8'h31, 0, 0);
    run_op("add_ovf",   OP_ADD, 16'h7FFF, 16'h0001, 2'b00, 1'b1, 1'b0, 16'h0,    8'h12, 0, 0);
    run_op("sub_neg",   OP_SUB, 16'd5,    16'd9,    2'b01, 1'b1, 1'b1, 16'h5555, 8'h22, 0, 0);
    run_op("sub_ovf",   OP_SUB, 16'h8000, 16'h0001, 2'b00, 1'b1, 1'b0, 16'h0,    8'h23, 0, 0);
    run_op("and",       OP_AND, 16'hF0F0, 16'h3C3C, 2'b11, 1'b1, 1'b0, 16'h0001, 8'h44, 0, 0);
    run_op("or",        OP_OR,  16'hF0F0, 16'h0F01, 2'b00, 1'b1, 1'b0, 16'h0,    8'h45, 0, 0);
    run_op("sll",       OP_SLL, 16'h8421, 16'h0013, 2'b00, 1'b1, 1'b0, 16'h0,    8'h46, 0, 0);
    run_op("srl",       OP_SRL, 16'h8421, 16'h0004, 2'b00, 1'b1, 1'b0, 16'h0,    8'h47, 0, 0);
    run_op("sra",       OP_SRA, 16'h8421, 16'h0004, 2'b00, 1'b1, 1'b0, 16'h0,    8'h48, 0, 0);
    run_op("mul_m3_5",  OP_MUL, 16'hFFFD, 16'd5,    2'b01, 1'b1, 1'b1, 16'hCAFE, 8'h71, 0, 0);
    run_op("div_17_5",  OP_DIV, 16'd17,   16'd5,    2'b00, 1'b1, 1'b0, 16'h0,    8'h81, 0, 0);
    run_op("div_m17_5", OP_DIV, 16'hFFEF, 16'd5,    2'b00, 1'b1, 1'b0, 16'h0,    8'h82, 0, 0);
    run_op("div0",      OP_DIV, 16'd9,    16'd0,    2'b10, 1'b1, 1'b0, 16'h7777, 8'h83, 0, 0);
    run_op("div_min_m1",OP_DIV, 16'h8000, 16'hFFFF, 2'b00, 1'b1, 1'b0, 16'h0,    8'h84, 0, 0);
    run_op("mul_min",   OP_MUL, 16'h8000, 16'h8000, 2'b00, 1'b1, 1'b0, 16'h0,    8'h72, 0, 0);
    run_op("mul_halt",  OP_MUL, 16'd1234, 16'hFFB3, 2'b11, 1'b1, 1'b1, 16'h0F0F, 8'h73, 6, 5);

    for (int i = 0; i < 4; i++) begin
      run_op("rnd_mul", OP_MUL, 16'($urandom), 16'($urandom), 2'b00, 1'b1, 1'b0,
             16'h0, 8'(i), 0, 0);
      run_op("rnd_div", OP_DIV, 16'($urandom), 16'($urandom_range(1, 65535)),
             2'b00, 1'b1, 1'b0, 16'h0, 8'(i), 0, 0);
    end

    set_inputs(OP_AND, 16'h0, 16'h0, 2'b00, 1'b0, 1'b0, 16'h0, 8'h00);
    @(posedge clk); #1;
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stage_two.md
Name: stage_two

Overview:
- Execute stage of the 16-bit pipelined CPU. Sits directly downstream of stage_one.
- Consumes stage_one's flopped ALU operands, ALU control and sideband fields.
- Performs single-cycle ALU ops, plus iterative signed multiply and divide.
- Registers the result and sidebands for the memory/writeback stage. While a multi-cycle op runs it raises busy, which holds stage_one's pipeline flop and PC.

Parameters:
WIDTH, 16, datapath width; result bus is 2*WIDTH
ITERS, 16, mul/div iteration count; must equal WIDTH

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset
halt_sys  in  1  freezes all state (FSM, counters, output flop)
in_alu_a  in  16  operand A from stage_one
in_alu_b  in  16  operand B (reg or zero-extended immediate)
in_alu_ctrl  in  4  control_e op: ADD, SUB, AND, OR, SLL, SRL, SRA, MUL, DIV
in_memc  in  2  memory control, passed through
in_reg_wr  in  1  register write enable, passed through
in_R0_en  in  1  upper-half write to R0, passed through
in_R1_data  in  16  store data, passed through
in_instr  in  8  {opcode, r1} tag, passed through
busy  out  1  combinational stall request to stage_one
out_alu_result  out  32  registered result; also the aluout forwarding bus
out_memc  out  2  registered
out_reg_wr  out  1  registered; forced 0 on overflow or div0
out_R0_en  out  1  registered
out_R1_data  out  16  registered
out_instr  out  8  registered
out_overflow  out  1  registered signed overflow flag
out_div0  out  1  registered divide-by-zero flag

Behaviour:
- Reset (rst=0, async):
  - FSM goes to IDLE; counter and operand/accumulator registers clear.
  - All outputs are 0: busy=0, out_alu_result=0, out_memc=0, out_reg_wr=0, out_R0_en=0, out_R1_data=0, out_instr=0, out_overflow=0, out_div0=0.
  - Reset during MUL/DIV aborts the op; no partial result is ever emitted.
- halt_sys=1: no register changes; busy holds its current value.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE, op not MUL/DIV:
  - busy=0; output flop loads the result and all sidebands at the next edge (latency 1).
  - ADD/SUB: result[15:0] = a±b; result[31:16] = sign-extension; out_overflow = signed overflow, in which case out_reg_wr=0.
  - AND/OR: bitwise.
  - SLL/SRL/SRA: shift amount is b[3:0].
- IDLE, op MUL or DIV with b≠0:
  - busy=1 combinationally in the same cycle.
  - Capture operand magnitudes and result signs; counter=0; go to MUL or DIV.
  - Output flop loads a bubble: out_reg_wr=0, out_memc=0, flags=0, other fields 0.
- IDLE, DIV with b=0:
  - Single-cycle: result=0, out_div0=1, out_reg_wr=0, busy=0. No FSM entry.
- MUL: radix-2 shift-add on unsigned magnitudes, one bit per cycle.
- DIV: restoring divide on unsigned magnitudes, one bit per cycle.
- MUL/DIV common rules:
  - busy=1 and the output flop loads a bubble every cycle.
  - After ITERS cycles (counter==ITERS-1) go to DONE.
- DONE:
  - busy=0; apply signs.
  - MUL: 32-bit signed product.
  - DIV: quotient truncates toward zero and goes to [15:0]; remainder takes the sign of the dividend and goes to [31:16].
  - DIV -32768/-1: quotient 0x8000, out_overflow=1, out_reg_wr=0.
  - Output flop loads the result with the sidebands still held at the inputs; go to IDLE.
- Timing for MUL/DIV:
  - busy is high for ITERS+1 cycles.
  - Result appears ITERS+2 edges after the op first presents.
  - stage_one advances on the DONE edge, so the same op is not re-triggered.
- Inputs are sampled only in IDLE and DONE; input changes during MUL/DIV are ignored.

Test Plan:
- Reset: drive rst=0 mid-MUL (counter=7) → all outputs 0 immediately, busy=0. Release rst, present ADD 3+4 → out_alu_result=32'h0000_0007 one edge later.
- ADD overflow: ADD a=16'h7FFF, b=16'h0001, in_reg_wr=1 → out_alu_result[15:0]=16'h8000, out_overflow=1, out_reg_wr=0, busy never asserted.
- MUL: MUL a=-3, b=5, in_R0_en=1 → busy high exactly 17 cycles, bubbles during busy, then out_alu_result=32'hFFFF_FFF1, out_R0_en=1, busy=0.
- DIV signed: DIV a=17, b=5 → 32'h0002_0003. DIV a=-17, b=5 → 32'hFFFE_FFFD. Both with 17-cycle busy.
- Divide by zero: DIV a=9, b=0 → busy stays 0, next edge out_alu_result=0, out_div0=1, out_reg_wr=0.
- Halt: assert halt_sys for 5 cycles at MUL counter=4 → counter, busy and outputs frozen. On release the op completes with total busy = 17 + 5 cycles and a correct product.
